alu_seq_ctrl: RTL

Multi-cycle ALU sequencer built around a single shared 8-bit AdderSubtractor instance. It accepts one operation at a time over a valid/ready input handshake: ADD, SUB, unsigned MUL (shift-add) or unsigned DIV (restoring). It steps the adder once per cycle for the required number of iterations. It presents the result on a valid/ready output handshake and is the control layer between the ALU's operand source and its result consumer.

---
 rtl/alu_pkg.sv | 15 +
 rtl/alu_seq_ctrl_addsub.sv | 17 +
 rtl/alu_seq_ctrl.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode, state and width constants shared by the ALU sequencer
package alu_pkg;

  localparam int DEFAULT_WIDTH = 8;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/alu_seq_ctrl_addsub.sv
// rtl/alu_seq_ctrl_addsub.sv - shared combinational adder/subtractor (select=1 gives A+~B+1)
module AdderSubtractor #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] operandA,
  input  logic [WIDTH-1:0] operandB,
  input  logic             select,
  output logic [WIDTH-1:0] result,
  output logic             carryOut
);

  // Two's-complement subtract by inverting B and injecting select as carry-in
  assign {carryOut, result} = {1'b0, operandA}
                            + {1'b0, operandB ^ {WIDTH{select}}}
                            + {{WIDTH{1'b0}}, select};

endmodule

// File: rtl/alu_seq_ctrl.sv
// rtl/alu_seq_ctrl.sv - multi-cycle ADD/SUB/MUL/DIV sequencer around one shared adder
module alu_seq_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inValid,
  output logic             inReady,
  input  logic [1:0]       opcode,
  input  logic [WIDTH-1:0] operandA,
  input  logic [WIDTH-1:0] operandB,
  output logic             outValid,
  input  logic             outReady,
  output logic [WIDTH-1:0] resultLo,
  output logic [WIDTH-1:0] resultHi,
  output logic             carryOut,
  output logic             divByZero,
  output logic             busy
);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] b_q, b_d;
  // lo_q: A for ADD/SUB, multiplier for MUL, dividend/quotient for DIV
  logic [WIDTH-1:0] lo_q, lo_d;
  // hi_q: partial product high half for MUL, remainder for DIV
  logic [WIDTH-1:0] hi_q, hi_d;
  logic             dbz_q, dbz_d;
  logic [WIDTH-1:0] res_lo_q, res_lo_d, res_hi_q, res_hi_d;
  logic             carry_q, carry_d, dbz_out_q, dbz_out_d;

  logic [WIDTH-1:0] add_a, add_b, add_sum;
  logic             add_sel, add_co;
  logic [WIDTH-1:0] iter_hi, iter_lo, mul_hp;
  logic             mul_c, div_qbit;

  AdderSubtractor #(.WIDTH(WIDTH)) u_addsub (
    .operandA (add_a),
    .operandB (add_b),
    .select   (add_sel),
    .result   (add_sum),
    .carryOut (add_co)
  );

  // Route the shared adder according to the operation in flight
  always_comb begin
    add_b   = b_q;
    add_a   = lo_q;
    add_sel = 1'b0;
    case (op_q)
      OP_SUB: add_sel = 1'b1;
      OP_MUL: add_a   = hi_q;
      OP_DIV: begin
        add_a   = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
        add_sel = 1'b1;
      end
      default: ;
    endcase
  end

  // One shift-add or restoring-divide step built on the adder output
  always_comb begin
    mul_hp   = lo_q[0] ? add_sum : hi_q;
    mul_c    = lo_q[0] & add_co;
    // The bit shifted out of R means t >= 2^WIDTH > B, so it also sets the quotient bit
    div_qbit = hi_q[WIDTH-1] | add_co;
    iter_hi  = hi_q;
    iter_lo  = lo_q;
    case (op_q)
      OP_MUL: begin
        iter_hi = {mul_c, mul_hp[WIDTH-1:1]};
        iter_lo = {mul_hp[0], lo_q[WIDTH-1:1]};
      end
      OP_DIV: begin
        iter_hi = div_qbit ? add_sum : {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
        iter_lo = {lo_q[WIDTH-2:0], div_qbit};
      end
      default: ;
    endcase
  end

  // Next-state logic: accept in IDLE, iterate in EXEC, hold results in DONE
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    b_d       = b_q;
    lo_d      = lo_q;
    hi_d      = hi_q;
    dbz_d     = dbz_q;
    res_lo_d  = res_lo_q;
    res_hi_d  = res_hi_q;
    carry_d   = carry_q;
    dbz_out_d = dbz_out_q;
    case (state_q)
      ST_IDLE: begin
        if (inValid) begin
          op_d    = opcode;
          b_d     = operandB;
          lo_d    = operandA;
          hi_d    = '0;
          dbz_d   = (opcode == OP_DIV) && (operandB == '0);
          cnt_d   = ((opcode == OP_MUL) || ((opcode == OP_DIV) && (operandB != '0)))
                    ? CNT_W'(WIDTH) : CNT_W'(1);
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        cnt_d = cnt_q - CNT_W'(1);
        hi_d  = iter_hi;
        lo_d  = iter_lo;
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_DONE;
          if (dbz_q) begin
            res_lo_d  = '1;
            res_hi_d  = lo_q;
            carry_d   = 1'b0;
            dbz_out_d = 1'b1;
          end else if ((op_q == OP_ADD) || (op_q == OP_SUB)) begin
            res_lo_d  = add_sum;
            res_hi_d  = '0;
            carry_d   = add_co;
            dbz_out_d = 1'b0;
          end else begin
            res_lo_d  = iter_lo;
            res_hi_d  = iter_hi;
            carry_d   = 1'b0;
            dbz_out_d = 1'b0;
          end
        end
      end
      ST_DONE: begin
        if (outReady) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      op_q      <= OP_ADD;
      b_q       <= '0;
      lo_q      <= '0;
      hi_q      <= '0;
      dbz_q     <= 1'b0;
      res_lo_q  <= '0;
      res_hi_q  <= '0;
      carry_q   <= 1'b0;
      dbz_out_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      b_q       <= b_d;
      lo_q      <= lo_d;
      hi_q      <= hi_d;
      dbz_q     <= dbz_d;
      res_lo_q  <= res_lo_d;
      res_hi_q  <= res_hi_d;
      carry_q   <= carry_d;
      dbz_out_q <= dbz_out_d;
    end
  end

  assign inReady   = (state_q == ST_IDLE);
  assign outValid  = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign resultLo  = res_lo_q;
  assign resultHi  = res_hi_q;
  assign carryOut  = carry_q;
  assign divByZero = dbz_out_q;

endmodule
